// File: rtl/draw_pkg.sv
// Shared types and constants for the SPI drawing-command path into the pixel store.
package draw_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned PKT_BYTES = 4;

  typedef struct packed {
    logic       brush;
    logic [2:0] color;
    logic [9:0] x;
    logic [9:0] y;
  } draw_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_B3,
    ST_CHECK
  } spi_state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Valid/ready write-command port between the SPI decoder and the pixel store.
interface spi_cmd_decoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_brush;
  logic [2:0] cmd_color;
  logic [9:0] cmd_x;
  logic [9:0] cmd_y;

  modport master (output cmd_valid, cmd_brush, cmd_color, cmd_x, cmd_y, input cmd_ready);
  modport slave  (input cmd_valid, cmd_brush, cmd_color, cmd_x, cmd_y, output cmd_ready);
endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte engine oversampled in clk: synchronizers, edge detect, MSB-first
// shift-in of sdi and shift-out of the status byte on sdo.
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  input  logic [7:0] status_byte,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       cs_fall,
  output logic       cs_high,
  output logic       bit_busy,
  output logic       sdo
);

  // Each stage holds {sck, sdi, cs_n}; index SYNC_STAGES-1 is the oldest sample.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic       cs_prev_q, cs_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_q, tx_d;
  logic       sck_s, sdi_s, cs_s;
  logic       sck_rise, sck_fall;

  assign sck_s    = sync_q[SYNC_STAGES-1][2];
  assign sdi_s    = sync_q[SYNC_STAGES-1][1];
  assign cs_s     = sync_q[SYNC_STAGES-1][0];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_high  = cs_s;
  assign bit_busy = (bit_cnt_q != 3'd0);
  assign rx_byte  = {shift_q[6:0], sdi_s};
  assign byte_done = ~cs_s & sck_rise & (bit_cnt_q == 3'd7);
  assign sdo      = ~cs_s & tx_q[7];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sck, sdi, cs_n};
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    if (cs_s) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sck_rise) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The falling edge after a completed byte reloads status so its MSB is
    // on sdo before the next byte's first rising edge.
    if (cs_fall) begin
      tx_d = status_byte;
    end else if (~cs_s && sck_fall) begin
      tx_d = (bit_cnt_q == 3'd0) ? status_byte : {tx_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
    end else begin
      sync_q     <= sync_d;
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Assembles 4-byte SPI packets into drawing commands, range-checks them and hands
// them to the pixel store over valid/ready; drops are counted in err_count.
module spi_cmd_decoder
  import draw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned X_LIMIT     = SCREEN_W,
  parameter int unsigned Y_LIMIT     = SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs_n,
  output logic               sdo,
  spi_cmd_decoder_if.master  cmd,
  output logic [7:0]         err_count
);

  localparam logic [10:0] X_LIM = 11'(X_LIMIT);
  localparam logic [10:0] Y_LIM = 11'(Y_LIMIT);

  logic       byte_done, cs_fall, cs_high, bit_busy;
  logic [7:0] rx_byte, status_byte;

  spi_state_t state_q, state_d;
  draw_cmd_t  pkt_q, pkt_d, cmd_q, cmd_d;
  logic       valid_q, valid_d;
  logic [7:0] err_q, err_d;
  logic       ovf_seen_q, ovf_seen_d, range_seen_q, range_seen_d, abort_seen_q, abort_seen_d;
  logic       abort, range_bad, overflow;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .cs_n        (cs_n),
    .status_byte (status_byte),
    .byte_done   (byte_done),
    .rx_byte     (rx_byte),
    .cs_fall     (cs_fall),
    .cs_high     (cs_high),
    .bit_busy    (bit_busy),
    .sdo         (sdo)
  );

  assign status_byte = {valid_q, ovf_seen_q, range_seen_q, abort_seen_q, err_q[3:0]};

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    cmd_d     = cmd_q;
    valid_d   = valid_q & ~cmd.cmd_ready;
    abort     = 1'b0;
    range_bad = 1'b0;
    overflow  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_B0;
      ST_B0, ST_B1, ST_B2, ST_B3: begin
        if (cs_high) begin
          state_d = ST_IDLE;
          abort   = (state_q != ST_B0) | bit_busy;
        end else if (byte_done) begin
          unique case (state_q)
            ST_B0: begin
              pkt_d.color  = rx_byte[7:5];
              pkt_d.brush  = rx_byte[4];
              pkt_d.x[9:8] = rx_byte[1:0];
              state_d      = ST_B1;
            end
            ST_B1: begin
              pkt_d.x[7:0] = rx_byte;
              state_d      = ST_B2;
            end
            ST_B2: begin
              pkt_d.y[9:8] = rx_byte[1:0];
              state_d      = ST_B3;
            end
            default: begin
              pkt_d.y[7:0] = rx_byte;
              state_d      = ST_CHECK;
            end
          endcase
        end
      end
      ST_CHECK: begin
        state_d = ST_B0;
        if (({1'b0, pkt_q.x} >= X_LIM) || ({1'b0, pkt_q.y} >= Y_LIM)) begin
          range_bad = 1'b1;
        end else if (valid_q && !cmd.cmd_ready) begin
          overflow = 1'b1;
        end else begin
          cmd_d   = pkt_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = (abort | range_bad | overflow) ? sat_inc(err_q) : err_q;
    // Sticky flags are reported in the frame-start status byte, then restart.
    ovf_seen_d   = (ovf_seen_q   & ~cs_fall) | overflow;
    range_seen_d = (range_seen_q & ~cs_fall) | range_bad;
    abort_seen_d = (abort_seen_q & ~cs_fall) | abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pkt_q        <= '0;
      cmd_q        <= '0;
      valid_q      <= 1'b0;
      err_q        <= '0;
      ovf_seen_q   <= 1'b0;
      range_seen_q <= 1'b0;
      abort_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      cmd_q        <= cmd_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      ovf_seen_q   <= ovf_seen_d;
      range_seen_q <= range_seen_d;
      abort_seen_q <= abort_seen_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_brush = cmd_q.brush;
  assign cmd.cmd_color = cmd_q.color;
  assign cmd.cmd_x     = cmd_q.x;
  assign cmd.cmd_y     = cmd_q.y;
  assign err_count     = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: packet table plus overflow, sdo status,
// abort, reset-mid-packet and err_count saturation sequences.
module tb_spi_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n = 1'b1;
  logic       sdo;
  logic [7:0] err_count;

  spi_cmd_decoder_if bus ();

  spi_cmd_decoder #(.SYNC_STAGES(2), .X_LIMIT(640), .Y_LIMIT(480)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .sdo       (sdo),
    .cmd       (bus.master),
    .err_count (err_count)
  );

  always #20 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Transfer monitor, sampled on the inactive edge.
  int         xfer_cnt = 0;
  logic       last_brush = 1'b0;
  logic [2:0] last_color = '0;
  logic [9:0] last_x = '0;
  logic [9:0] last_y = '0;

  always @(negedge clk) begin
    if (!reset && bus.cmd_valid && bus.cmd_ready) begin
      xfer_cnt   <= xfer_cnt + 1;
      last_brush <= bus.cmd_brush;
      last_color <= bus.cmd_color;
      last_x     <= bus.cmd_x;
      last_y     <= bus.cmd_y;
    end
  end

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int         exp_xfer;
    logic       exp_brush;
    logic [2:0] exp_color;
    logic [9:0] exp_x, exp_y;
    logic [7:0] exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cs_n = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] so);
    so = '0;
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      tick(4);
      so[i] = sdo;
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] so;
    send_bits(b0, 8, so);
    send_bits(b1, 8, so);
    send_bits(b2, 8, so);
    send_bits(b3, 8, so);
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  initial begin
    int         base;
    logic [7:0] so;

    vecs[0] = '{8'hB1, 8'h40, 8'h00, 8'hF0, 1, 1'b1, 3'd5, 10'd320, 10'd240, 8'd0};
    vecs[1] = '{8'h02, 8'h80, 8'h00, 8'h10, 0, 1'b0, 3'd0, 10'd0,   10'd0,   8'd1};
    vecs[2] = '{8'h02, 8'h7F, 8'h01, 8'hDF, 1, 1'b0, 3'd0, 10'd639, 10'd479, 8'd0};
    vecs[3] = '{8'h00, 8'h00, 8'h01, 8'hE0, 0, 1'b0, 3'd0, 10'd0,   10'd0,   8'd1};
    vecs[4] = '{8'hEE, 8'h10, 8'hFC, 8'h05, 1, 1'b0, 3'd7, 10'd528, 10'd5,   8'd0};
    vecs[5] = '{8'h13, 8'h00, 8'h00, 8'h00, 0, 1'b0, 3'd0, 10'd0,   10'd0,   8'd1};

    bus.cmd_ready = 1'b0;
    do_reset();
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_brush", 32'(bus.cmd_brush), 0);
    check("rst_color", 32'(bus.cmd_color), 0);
    check("rst_x", 32'(bus.cmd_x), 0);
    check("rst_y", 32'(bus.cmd_y), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_sdo", 32'(sdo), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.cmd_ready = 1'b1;
      base = xfer_cnt;
      frame_start();
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      frame_end();
      tick(12);
      check($sformatf("vec%0d_xfers", i), 32'(xfer_cnt - base), 32'(vecs[i].exp_xfer));
      if (vecs[i].exp_xfer != 0) begin
        check($sformatf("vec%0d_brush", i), 32'(last_brush), 32'(vecs[i].exp_brush));
        check($sformatf("vec%0d_color", i), 32'(last_color), 32'(vecs[i].exp_color));
        check($sformatf("vec%0d_x", i), 32'(last_x), 32'(vecs[i].exp_x));
        check($sformatf("vec%0d_y", i), 32'(last_y), 32'(vecs[i].exp_y));
      end
      check($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
    end

    // Back-to-back packets with the pixel store stalled: second one overflows.
    do_reset();
    bus.cmd_ready = 1'b0;
    frame_start();
    send_pkt(8'hB1, 8'h40, 8'h00, 8'hF0);
    send_pkt(8'h20, 8'h05, 8'h00, 8'h07);
    frame_end();
    tick(10);
    check("ovf_valid_held", 32'(bus.cmd_valid), 1);
    check("ovf_x_held", 32'(bus.cmd_x), 320);
    check("ovf_y_held", 32'(bus.cmd_y), 240);
    check("ovf_err", 32'(err_count), 1);

    // Status byte shifted out at the start of the next frame.
    frame_start();
    send_bits(8'h00, 8, so);
    frame_end();
    check("sdo_status", 32'(so), 32'hC1);
    check("sdo_abort_err", 32'(err_count), 2);
    check("sdo_x_still_held", 32'(bus.cmd_x), 320);

    base = xfer_cnt;
    bus.cmd_ready = 1'b1;
    tick(10);
    check("ovf_release_xfers", 32'(xfer_cnt - base), 1);
    check("ovf_release_x", 32'(last_x), 320);
    check("ovf_release_valid", 32'(bus.cmd_valid), 0);

    // Abort after two bytes and three bits, then a clean packet.
    do_reset();
    bus.cmd_ready = 1'b1;
    frame_start();
    send_bits(8'hB1, 8, so);
    send_bits(8'h40, 8, so);
    send_bits(8'h00, 3, so);
    frame_end();
    check("abort_err", 32'(err_count), 1);
    base = xfer_cnt;
    frame_start();
    send_pkt(8'h20, 8'h05, 8'h00, 8'h07);
    frame_end();
    tick(10);
    check("abort_next_xfers", 32'(xfer_cnt - base), 1);
    check("abort_next_x", 32'(last_x), 5);
    check("abort_next_y", 32'(last_y), 7);
    check("abort_next_color", 32'(last_color), 1);
    check("abort_next_err", 32'(err_count), 1);

    // Reset during byte2 with a held command and a nonzero error count.
    do_reset();
    bus.cmd_ready = 1'b0;
    frame_start();
    send_pkt(8'h02, 8'h80, 8'h00, 8'h10);
    send_pkt(8'hB1, 8'h40, 8'h00, 8'hF0);
    send_bits(8'h20, 8, so);
    send_bits(8'h05, 8, so);
    send_bits(8'h00, 3, so);
    check("pre_rst_valid", 32'(bus.cmd_valid), 1);
    check("pre_rst_err", 32'(err_count), 1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.cmd_valid), 0);
    check("midrst_x", 32'(bus.cmd_x), 0);
    check("midrst_y", 32'(bus.cmd_y), 0);
    check("midrst_color", 32'(bus.cmd_color), 0);
    check("midrst_brush", 32'(bus.cmd_brush), 0);
    check("midrst_err", 32'(err_count), 0);
    tick(2);
    reset = 1'b0;
    cs_n = 1'b1;
    tick(8);
    bus.cmd_ready = 1'b1;
    base = xfer_cnt;
    frame_start();
    send_pkt(8'hB1, 8'h40, 8'h00, 8'hF0);
    frame_end();
    tick(10);
    check("postrst_xfers", 32'(xfer_cnt - base), 1);
    check("postrst_x", 32'(last_x), 320);
    check("postrst_y", 32'(last_y), 240);
    check("postrst_err", 32'(err_count), 0);

    // err_count saturation through repeated one-bit aborts.
    do_reset();
    for (int n = 0; n < 260; n++) begin
      cs_n = 1'b0;
      tick(6);
      send_bits(8'h80, 1, so);
      tick(2);
      cs_n = 1'b1;
      tick(6);
    end
    check("err_saturate", 32'(err_count), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
